// File: rtl/clk_div_monitor.sv
// Divided-clock checker: measures period and high time of clk_mon in clk_in cycles
// and reports lock, sticky period/duty errors and a stuck-clock timeout.
module clk_div_monitor #(
    parameter int EXP_PERIOD = 4,
    parameter int EXP_HIGH   = 2,
    parameter int CNT_W      = 16,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             clk_mon,
    input  logic             clear_err,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             err_period,
    output logic             err_duty,
    output logic             timeout
);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]  EXP_P    = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0]  EXP_H    = CNT_W'(EXP_HIGH);
    localparam logic [CNT_W-1:0]  TO_MAX   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  TO_ARM   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  HCNT_MAX = '1;
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_COUNT);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t             state;
    logic               mon_q;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   hcnt;
    logic [GOOD_W-1:0]  good_cnt;

    logic rise;
    logic per_ok;
    logic high_ok;
    logic expire;

    // clk_mon comes from clk_in flops, so a single register is enough for edge detect.
    assign rise    = clk_mon & ~mon_q;
    assign per_ok  = (cnt == EXP_P);
    assign high_ok = (hcnt == EXP_H);
    assign expire  = ~rise & (cnt == TO_ARM);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state      <= IDLE;
            mon_q      <= 1'b0;
            cnt        <= '0;
            hcnt       <= '0;
            good_cnt   <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            err_period <= 1'b0;
            err_duty   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            mon_q      <= clk_mon;
            meas_valid <= 1'b0;

            if (rise) begin
                cnt  <= CNT_W'(1);
                hcnt <= CNT_W'(1);
            end else begin
                if (cnt != TO_MAX)
                    cnt <= cnt + 1'b1;
                if (clk_mon && hcnt != HCNT_MAX)
                    hcnt <= hcnt + 1'b1;
            end

            // NOTE: with non-blocking assignments the last one in the block wins,
            // so the error sets below take priority over this clear.
            if (clear_err) begin
                err_period <= 1'b0;
                err_duty   <= 1'b0;
            end

            if (rise) begin
                timeout <= 1'b0;
                state   <= MEASURE;
                // From IDLE the first rise only re-arms; the open period is not reported.
                if (state == MEASURE) begin
                    period     <= cnt;
                    high_time  <= hcnt;
                    meas_valid <= 1'b1;
                    if (per_ok && high_ok) begin
                        if (good_cnt != GOOD_MAX)
                            good_cnt <= good_cnt + 1'b1;
                        if (good_cnt >= GOOD_MAX - 1'b1)
                            locked <= 1'b1;
                    end else begin
                        good_cnt <= '0;
                        locked   <= 1'b0;
                    end
                    if (!per_ok)
                        err_period <= 1'b1;
                    if (!high_ok)
                        err_duty <= 1'b1;
                end
            end else if (expire) begin
                timeout  <= 1'b1;
                locked   <= 1'b0;
                good_cnt <= '0;
                state    <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor with default parameters (4/2 expected, lock 4, timeout 64).
module tb_clk_div_monitor;
    logic        clk_in = 1'b0;
    logic        reset;
    logic        clk_mon;
    logic        clear_err;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        meas_valid;
    logic        locked;
    logic        err_period;
    logic        err_duty;
    logic        timeout;

    int tests_run = 0;
    int fail_cnt  = 0;

    // Observations taken right after the rising-edge cycle of each wave.
    logic        mv_rise;
    logic        to_rise;
    logic [15:0] p_rise;
    logic [15:0] ht_rise;
    int          mv_extra;

    clk_div_monitor dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .clk_mon    (clk_mon),
        .clear_err  (clear_err),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .err_period (err_period),
        .err_duty   (err_duty),
        .timeout    (timeout)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clk_mon period: h cycles high then l cycles low; clear_err pulsed on cycle clr_at.
    task automatic wave(input int h, input int l, input int clr_at);
        mv_extra = 0;
        for (int i = 0; i < h + l; i++) begin
            clear_err = (i == clr_at);
            clk_mon   = (i < h);
            @(posedge clk_in);
            #1;
            if (i == 0) begin
                mv_rise = meas_valid;
                to_rise = timeout;
                p_rise  = period;
                ht_rise = high_time;
            end else if (meas_valid) begin
                mv_extra++;
            end
        end
        clear_err = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        clk_mon   = 1'b0;
        clear_err = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        tests_run++;
        if ({period, high_time} !== 32'd0) begin
            fail_cnt++;
            $display("FAIL reset_meas: period=%0d high_time=%0d, required 0/0", period, high_time);
        end
        tests_run++;
        if ({meas_valid, locked, err_period, err_duty, timeout} !== 5'b0) begin
            fail_cnt++;
            $display("FAIL reset_flags: got %b, required 00000",
                     {meas_valid, locked, err_period, err_duty, timeout});
        end
        reset = 1'b0;
    endtask

    task automatic test_lock();
        wave(2, 2, -1);
        tests_run++;
        if (mv_rise !== 1'b0) begin
            fail_cnt++;
            $display("FAIL lock_first_rise_valid: got %b, required 0", mv_rise);
        end
        wave(2, 2, -1);
        tests_run++;
        if (mv_rise !== 1'b1 || p_rise !== 16'd4 || ht_rise !== 16'd2) begin
            fail_cnt++;
            $display("FAIL lock_first_meas: valid=%b period=%0d high=%0d, required 1/4/2",
                     mv_rise, p_rise, ht_rise);
        end
        tests_run++;
        if (mv_extra !== 0) begin
            fail_cnt++;
            $display("FAIL lock_valid_width: extra pulses %0d, required 0", mv_extra);
        end
        wave(2, 2, -1);
        wave(2, 2, -1);
        tests_run++;
        if (locked !== 1'b0) begin
            fail_cnt++;
            $display("FAIL lock_after_3_good: locked=%b, required 0", locked);
        end
        wave(2, 2, -1);
        tests_run++;
        if (locked !== 1'b1) begin
            fail_cnt++;
            $display("FAIL lock_after_4_good: locked=%b, required 1", locked);
        end
        tests_run++;
        if ({err_period, err_duty, timeout} !== 3'b0) begin
            fail_cnt++;
            $display("FAIL lock_no_errors: got %b, required 000", {err_period, err_duty, timeout});
        end
    endtask

    task automatic test_mismatch();
        wave(3, 2, -1);
        tests_run++;
        if (p_rise !== 16'd4 || locked !== 1'b1) begin
            fail_cnt++;
            $display("FAIL mm_prev_good: period=%0d locked=%b, required 4/1", p_rise, locked);
        end
        wave(2, 2, -1);
        tests_run++;
        if (mv_rise !== 1'b1 || p_rise !== 16'd5 || ht_rise !== 16'd3) begin
            fail_cnt++;
            $display("FAIL mm_meas: valid=%b period=%0d high=%0d, required 1/5/3",
                     mv_rise, p_rise, ht_rise);
        end
        tests_run++;
        if ({err_period, err_duty, locked} !== 3'b110) begin
            fail_cnt++;
            $display("FAIL mm_flags: errp/errd/locked=%b, required 110",
                     {err_period, err_duty, locked});
        end
        repeat (3) wave(2, 2, -1);
        tests_run++;
        if (locked !== 1'b0) begin
            fail_cnt++;
            $display("FAIL mm_relock_early: locked=%b, required 0", locked);
        end
        wave(2, 2, -1);
        tests_run++;
        if ({locked, err_period, err_duty} !== 3'b111) begin
            fail_cnt++;
            $display("FAIL mm_relock_sticky: locked/errp/errd=%b, required 111",
                     {locked, err_period, err_duty});
        end
        wave(2, 2, 2);
        tests_run++;
        if ({locked, err_period, err_duty} !== 3'b100) begin
            fail_cnt++;
            $display("FAIL mm_clear: locked/errp/errd=%b, required 100",
                     {locked, err_period, err_duty});
        end
    endtask

    task automatic test_clear_coincident();
        wave(3, 2, -1);
        wave(2, 2, 0);
        tests_run++;
        if ({err_period, err_duty} !== 2'b11) begin
            fail_cnt++;
            $display("FAIL clr_set_wins: errp/errd=%b, required 11", {err_period, err_duty});
        end
        wave(2, 2, 2);
        tests_run++;
        if ({err_period, err_duty} !== 2'b00) begin
            fail_cnt++;
            $display("FAIL clr_alone: errp/errd=%b, required 00", {err_period, err_duty});
        end
    endtask

    task automatic test_timeout();
        repeat (3) wave(2, 2, -1);
        tests_run++;
        if (locked !== 1'b1) begin
            fail_cnt++;
            $display("FAIL to_prelock: locked=%b, required 1", locked);
        end
        // Last wave left cnt at 4, so the 60th extra low cycle brings it to 64.
        clk_mon = 1'b0;
        for (int j = 1; j <= 70; j++) begin
            @(posedge clk_in);
            #1;
            if (j == 59) begin
                tests_run++;
                if (timeout !== 1'b0) begin
                    fail_cnt++;
                    $display("FAIL to_early: timeout=%b at low cycle 59, required 0", timeout);
                end
            end
            if (j == 60) begin
                tests_run++;
                if (timeout !== 1'b1 || locked !== 1'b0) begin
                    fail_cnt++;
                    $display("FAIL to_fire: timeout=%b locked=%b at low cycle 60, required 1/0",
                             timeout, locked);
                end
            end
        end
        wave(2, 2, -1);
        tests_run++;
        if (to_rise !== 1'b0 || mv_rise !== 1'b0) begin
            fail_cnt++;
            $display("FAIL to_restart: timeout=%b valid=%b on first rise, required 0/0",
                     to_rise, mv_rise);
        end
        wave(2, 2, -1);
        tests_run++;
        if (mv_rise !== 1'b1 || p_rise !== 16'd4) begin
            fail_cnt++;
            $display("FAIL to_remeasure: valid=%b period=%0d, required 1/4", mv_rise, p_rise);
        end
    endtask

    task automatic test_reset_mid();
        repeat (3) wave(2, 2, -1);
        tests_run++;
        if (locked !== 1'b1) begin
            fail_cnt++;
            $display("FAIL rst_prelock: locked=%b, required 1", locked);
        end
        clk_mon = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        reset   = 1'b1;
        clk_mon = 1'b0;
        @(posedge clk_in);
        #1;
        tests_run++;
        if ({period, high_time} !== 32'd0 ||
            {meas_valid, locked, err_period, err_duty, timeout} !== 5'b0) begin
            fail_cnt++;
            $display("FAIL rst_mid_outputs: period=%0d high=%0d flags=%b, required 0/0/00000",
                     period, high_time, {meas_valid, locked, err_period, err_duty, timeout});
        end
        reset = 1'b0;
        wave(2, 2, -1);
        tests_run++;
        if (mv_rise !== 1'b0) begin
            fail_cnt++;
            $display("FAIL rst_rearm: valid=%b on first rise, required 0", mv_rise);
        end
        wave(2, 2, -1);
        tests_run++;
        if (mv_rise !== 1'b1 || p_rise !== 16'd4 || ht_rise !== 16'd2) begin
            fail_cnt++;
            $display("FAIL rst_second_rise: valid=%b period=%0d high=%0d, required 1/4/2",
                     mv_rise, p_rise, ht_rise);
        end
    endtask

    task automatic test_stuck_high();
        int mv_seen;
        mv_seen = 0;
        reset   = 1'b1;
        clk_mon = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        reset   = 1'b0;
        clk_mon = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            @(posedge clk_in);
            #1;
            if (meas_valid) mv_seen++;
            if (i == 63) begin
                tests_run++;
                if (timeout !== 1'b0) begin
                    fail_cnt++;
                    $display("FAIL stuck_early: timeout=%b at cycle 63, required 0", timeout);
                end
            end
            if (i == 64) begin
                tests_run++;
                if (timeout !== 1'b1) begin
                    fail_cnt++;
                    $display("FAIL stuck_fire: timeout=%b at cycle 64, required 1", timeout);
                end
            end
        end
        tests_run++;
        if ({period, high_time} !== 32'd0 || mv_seen !== 0 || timeout !== 1'b1) begin
            fail_cnt++;
            $display("FAIL stuck_end: period=%0d high=%0d valids=%0d timeout=%b, required 0/0/0/1",
                     period, high_time, mv_seen, timeout);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_mismatch();
        test_clear_coincident();
        test_timeout();
        test_reset_mid();
        test_stuck_high();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
